// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern generator: FSM state encoding
// and the constants of the optional 16-bit Fibonacci gap-fill LFSR.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16+x^14+x^13+x^11+1 on a right-shifting register taps bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/seq_gen_lfsr.sv
// 16-bit Fibonacci LFSR supplying gap-fill bits; only built when
// SEQ_GEN_LFSR_FILL_EN is defined.
module seq_gen_lfsr
    import seq_gen_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic step,
    output logic bit_out
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else if (step) begin
            r_lfsr <= {^(r_lfsr & LFSR_TAPS), r_lfsr[15:1]};
        end
    end

    assign bit_out = r_lfsr[0];

endmodule

// File: rtl/seq_generator.sv
// Serial pattern generator: sends a latched pattern MSB-first, repeated with
// idle gaps. Define SEQ_GEN_LFSR_FILL_EN to fill gap cycles with LFSR bits.
module seq_generator
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [4:0]       pat_len,
    input  logic [CNT_W-1:0] reps,
    input  logic [3:0]       gap,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int LEN_W = 6;

    state_t             r_state;
    logic [PAT_W-1:0]   r_pat;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_bit;
    logic [CNT_W-1:0]   r_rep;
    logic [3:0]         r_gap;
    logic [3:0]         r_gcnt;
    logic               r_x;
    logic               r_x_valid;
    logic               r_busy;
    logic               r_done;

    logic [LEN_W-1:0]   w_len_in;
    logic [CNT_W-1:0]   w_reps_in;
    logic               w_more;
    logic               w_fill;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [4:0] l);
        if ({1'b0, l} > LEN_W'(PAT_W))
            return LEN_W'(PAT_W);
        return {1'b0, l};
    endfunction

    function automatic logic bit_at(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] idx);
        logic [PAT_W-1:0] t;
        t = p >> idx;
        return t[0];
    endfunction

    assign w_len_in  = clamp_len(pat_len);
    assign w_reps_in = (reps == '0) ? CNT_W'(1) : reps;
    // r_rep counts repetitions still to send, including the one in flight
    assign w_more    = (r_rep > CNT_W'(1));

`ifdef SEQ_GEN_LFSR_FILL_EN
    logic w_enter_gap;

    // Step exactly on the edges that load a gap bit into x, so every gap
    // cycle shows a fresh LFSR bit.
    assign w_enter_gap = !abort &&
        (((r_state == ST_SHIFT) && (r_bit == '0) && w_more && (r_gap != 4'd0)) ||
         ((r_state == ST_GAP) && (r_gcnt != 4'd0)));

    seq_gen_lfsr u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .step    (w_enter_gap),
        .bit_out (w_fill)
    );
`else
    assign w_fill = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pat     <= '0;
            r_len     <= '0;
            r_bit     <= '0;
            r_rep     <= '0;
            r_gap     <= '0;
            r_gcnt    <= '0;
            r_x       <= 1'b0;
            r_x_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        r_pat  <= pattern;
                        r_len  <= w_len_in;
                        r_rep  <= w_reps_in;
                        r_gap  <= gap;
                        r_busy <= 1'b1;
                        if (w_len_in == '0) begin
                            r_state   <= ST_DONE;
                            r_done    <= 1'b1;
                            r_x       <= 1'b0;
                            r_x_valid <= 1'b0;
                        end else begin
                            r_state   <= ST_SHIFT;
                            r_bit     <= w_len_in - LEN_W'(1);
                            r_x       <= bit_at(pattern, w_len_in - LEN_W'(1));
                            r_x_valid <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        r_state   <= ST_IDLE;
                        r_x       <= 1'b0;
                        r_x_valid <= 1'b0;
                        r_busy    <= 1'b0;
                    end else if (r_bit != '0) begin
                        r_bit <= r_bit - LEN_W'(1);
                        r_x   <= bit_at(r_pat, r_bit - LEN_W'(1));
                    end else if (w_more) begin
                        r_rep <= r_rep - CNT_W'(1);
                        if (r_gap != 4'd0) begin
                            r_state   <= ST_GAP;
                            r_gcnt    <= r_gap - 4'd1;
                            r_x       <= w_fill;
                            r_x_valid <= 1'b0;
                        end else begin
                            r_bit <= r_len - LEN_W'(1);
                            r_x   <= bit_at(r_pat, r_len - LEN_W'(1));
                        end
                    end else begin
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_x       <= 1'b0;
                        r_x_valid <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        r_state   <= ST_IDLE;
                        r_x       <= 1'b0;
                        r_busy    <= 1'b0;
                    end else if (r_gcnt == 4'd0) begin
                        r_state   <= ST_SHIFT;
                        r_bit     <= r_len - LEN_W'(1);
                        r_x       <= bit_at(r_pat, r_len - LEN_W'(1));
                        r_x_valid <= 1'b1;
                    end else begin
                        r_gcnt <= r_gcnt - 4'd1;
                        r_x    <= w_fill;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_x       <= 1'b0;
                    r_x_valid <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign x       = r_x;
    assign x_valid = r_x_valid;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_seq_generator.sv
// Self-checking bench for seq_generator: directed scenarios plus randomized
// transactions compared cycle by cycle against an expected-stream model.
module tb_seq_generator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] pattern;
    logic [4:0]  pat_len;
    logic [7:0]  reps;
    logic [3:0]  gap;
    logic        x;
    logic        x_valid;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0] kind;   // 0 = pattern bit, 1 = gap cycle, 2 = done cycle
        logic       b;
    } rec_t;

    rec_t        q[$];
    logic [15:0] m_lfsr = 16'hACE1;

    seq_generator #(.PAT_W(16), .CNT_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .pattern (pattern),
        .pat_len (pat_len),
        .reps    (reps),
        .gap     (gap),
        .x       (x),
        .x_valid (x_valid),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ex, input logic exv,
                              input logic eb, input logic ed);
        check_val({tag, ".x"},       {31'd0, x},       {31'd0, ex});
        check_val({tag, ".x_valid"}, {31'd0, x_valid}, {31'd0, exv});
        check_val({tag, ".busy"},    {31'd0, busy},    {31'd0, eb});
        check_val({tag, ".done"},    {31'd0, done},    {31'd0, ed});
    endtask

    // Next gap-fill bit: LFSR output when the fill option is built, else 0.
    task automatic model_fill(output logic b);
`ifdef SEQ_GEN_LFSR_FILL_EN
        logic fb;
        b      = m_lfsr[0];
        fb     = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
        m_lfsr = {fb, m_lfsr[15:1]};
`else
        b = 1'b0;
`endif
    endtask

    task automatic build(input logic [15:0] p, input logic [4:0] l,
                         input logic [7:0] r, input logic [3:0] g);
        int len_c;
        int reps_c;
        len_c  = (l > 5'd16) ? 16 : int'(l);
        reps_c = (r == 8'd0) ? 1 : int'(r);
        q.delete();
        if (len_c > 0) begin
            for (int i = 0; i < reps_c; i++) begin
                for (int bi = len_c - 1; bi >= 0; bi--)
                    q.push_back('{kind: 2'd0, b: p[bi]});
                if (i < reps_c - 1)
                    for (int k = 0; k < int'(g); k++)
                        q.push_back('{kind: 2'd1, b: 1'b0});
            end
        end
        q.push_back('{kind: 2'd2, b: 1'b0});
    endtask

    task automatic scramble();
        pattern = 16'($urandom);
        pat_len = 5'($urandom);
        reps    = 8'($urandom);
        gap     = 4'($urandom);
        start   = 1'($urandom_range(0, 1));
    endtask

    // abort_at/reset_at: record index at which to inject (-1 none, -2 random abort)
    task automatic run_txn(input string name, input logic [15:0] p, input logic [4:0] l,
                           input logic [7:0] r, input logic [3:0] g,
                           input int abort_at_in, input int reset_at, input bit junk);
        int   abort_at;
        logic ex;
        logic exv;
        logic ed;
        build(p, l, r, g);
        abort_at = abort_at_in;
        if (abort_at == -2)
            abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, q.size() - 1)) : -1;
        @(negedge clk);
        pattern = p; pat_len = l; reps = r; gap = g;
        start = 1'b1; abort = 1'b0;
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            ed = 1'b0;
            case (q[k].kind)
                2'd0:    begin ex = q[k].b; exv = 1'b1; end
                2'd1:    begin model_fill(ex); exv = 1'b0; end
                default: begin ex = 1'b0; exv = 1'b0; ed = 1'b1; end
            endcase
            check_outs($sformatf("%s.c%0d", name, k + 1), ex, exv, 1'b1, ed);
            if (k == abort_at) begin
                abort = 1'b1;
                if (junk) scramble(); else start = 1'b0;
                @(negedge clk);
                abort = 1'b0; start = 1'b0;
                check_outs($sformatf("%s.abort", name), 1'b0, 1'b0, 1'b0, 1'b0);
                return;
            end
            if (k == reset_at) begin
                reset = 1'b1; start = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                m_lfsr = 16'hACE1;
                check_outs($sformatf("%s.reset", name), 1'b0, 1'b0, 1'b0, 1'b0);
                return;
            end
            if (junk) scramble(); else start = 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
        check_outs($sformatf("%s.idle", name), 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; abort = 1'b0;
        pattern = 16'hFFFF; pat_len = 5'd4; reps = 8'd1; gap = 4'd0;
        repeat (3) @(negedge clk);
        check_outs("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        reset = 1'b0;
        m_lfsr = 16'hACE1;
        repeat (2) @(negedge clk);
        check_outs("after_reset", 1'b0, 1'b0, 1'b0, 1'b0);

        run_txn("single",   16'h000B, 5'd4,  8'd1, 4'd0, -1, -1, 1'b0);
        run_txn("repgap",   16'h000B, 5'd4,  8'd3, 4'd2, -1, -1, 1'b1);
        run_txn("abort",    16'h000B, 5'd4,  8'd1, 4'd0,  1, -1, 1'b0);
        run_txn("post_ab",  16'h000B, 5'd4,  8'd1, 4'd0, -1, -1, 1'b0);
        run_txn("len0",     16'hFFFF, 5'd0,  8'd2, 4'd3, -1, -1, 1'b1);
        run_txn("len20",    16'hA5C3, 5'd20, 8'd1, 4'd0, -1, -1, 1'b1);
        run_txn("reps0",    16'h0013, 5'd5,  8'd0, 4'd3, -1, -1, 1'b1);
        run_txn("gap_ab",   16'h0006, 5'd3,  8'd3, 4'd4,  4, -1, 1'b0);

        // Simultaneous start and abort in IDLE must not launch a transmission.
        @(negedge clk);
        pattern = 16'h000B; pat_len = 5'd4; reps = 8'd1; gap = 4'd0;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check_outs("start_abort.c1", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_outs("start_abort.c2", 1'b0, 1'b0, 1'b0, 1'b0);

        run_txn("rstgap",   16'h000B, 5'd4,  8'd3, 4'd2, -1,  4, 1'b1);
        run_txn("lfsr",     16'h000F, 5'd3,  8'd4, 4'd3, -1, -1, 1'b1);

        for (int t = 0; t < 30; t++) begin
            run_txn($sformatf("rnd%0d", t), 16'($urandom), 5'($urandom_range(0, 20)),
                    8'($urandom_range(0, 4)), 4'($urandom_range(0, 5)), -2, -1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_generator.md
SEQ_GENERATOR -- requirements
Module: seq_generator

Interface
REQ-001 Parameter PAT_W, default 16, pattern register width in bits.
REQ-002 Parameter CNT_W, default 8, repetition counter width in bits.
REQ-003 clk  input  1  single clock; all logic updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a transmission; sampled only in IDLE.
REQ-006 abort  input  1  terminates an active transmission.
REQ-007 pattern  input  PAT_W  bit pattern; transmitted MSB-first from bit pat_len-1 down to bit 0.
REQ-008 pat_len  input  5  number of pattern bits to send.
REQ-009 reps  input  CNT_W  number of pattern repetitions.
REQ-010 gap  input  4  idle cycles inserted between repetitions.
REQ-011 x  output  1  registered serial bit stream; feeds the seq_detector x input.
REQ-012 x_valid  output  1  high when x carries a pattern bit.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse on normal completion.

Function
REQ-015 The FSM SHALL have the states IDLE, SHIFT, GAP and DONE.
REQ-016 IDLE with start=1 and abort=0 SHALL latch pattern, pat_len, reps and gap, then enter SHIFT; the first bit appears on x in the next cycle.
REQ-017 While busy, changes on pattern, pat_len, reps, gap and start SHALL be ignored.
REQ-018 In SHIFT, x SHALL carry one pattern bit per cycle with x_valid=1, and a bit counter SHALL decrement from len-1 to 0.
REQ-019 After the last bit, the FSM SHALL enter GAP if repetitions remain and gap>0, re-enter SHIFT directly if repetitions remain and gap=0, and otherwise enter DONE.
REQ-020 In GAP, the FSM SHALL hold x_valid=0 and x=0 (see REQ-031), stay for exactly gap cycles, then return to SHIFT.
REQ-021 DONE SHALL last one cycle with done=1, x=0 and x_valid=0, then return to IDLE.
REQ-022 A pat_len of 0 SHALL skip SHIFT: the FSM enters DONE in the cycle after start, with no valid bits.
REQ-023 A pat_len greater than PAT_W SHALL be clamped to PAT_W.
REQ-024 A reps value of 0 SHALL be treated as 1.
REQ-025 An abort in SHIFT, GAP or DONE SHALL force IDLE on the next edge, with x=0, x_valid=0 and no done pulse.
REQ-026 If start and abort are both high in IDLE, abort SHALL win and the FSM SHALL stay in IDLE.
REQ-027 Total cycles from start to done SHALL be reps*len + (reps-1)*gap + 1.

Reset
REQ-028 On reset=1 at a clock edge, the FSM SHALL enter IDLE and drive x=0, x_valid=0, busy=0 and done=0.
REQ-029 Reset SHALL clear all counters and latched inputs, and reset SHALL take priority over start and abort.
REQ-030 A reset applied during SHIFT or GAP SHALL abandon the transmission with no done pulse.

Configuration
REQ-031 With macro SEQ_GEN_LFSR_FILL_EN defined, x during GAP SHALL carry the LSB of a 16-bit Fibonacci LFSR.
- Polynomial x^16+x^14+x^13+x^11+1.
- Seeded with 16'hACE1 on reset.
- Advances once per GAP cycle only; x_valid stays 0.
REQ-032 Without SEQ_GEN_LFSR_FILL_EN, x SHALL be 0 during GAP and no LFSR logic SHALL be synthesized.

Structure
REQ-033 Shared package seq_gen_pkg SHALL hold the FSM state encoding, the LFSR seed, and the LFSR tap constants.
REQ-034 The LFSR SHALL be a sub-module seq_gen_lfsr (ports clk, reset, step, bit_out), instantiated only under SEQ_GEN_LFSR_FILL_EN.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- Single pattern: pattern=16'h000B, pat_len=4, reps=1, gap=0, start at cycle 20 -> x=1,0,1,1 with x_valid=1 in cycles 21-24; done=1 in cycle 25; busy=0 in cycle 26.
- Repeats with gap: same pattern, reps=3, gap=2 -> stream 1011 00 1011 00 1011 (x_valid low in the gaps); done 17 cycles after start; seq_detector z asserts on each 1011.
- Abort: abort in the 2nd SHIFT cycle of the single-pattern case -> IDLE next cycle, x=0, no done pulse; a following start transmits correctly.
- Boundaries: pat_len=0 -> done in the cycle after start, x_valid never high; pat_len=20 sends 16 bits; reps=0 sends one repetition; start pulsed while busy has no effect.
- Reset mid-operation: reset during GAP -> next cycle all outputs 0 and state IDLE.
- LFSR fill (with SEQ_GEN_LFSR_FILL_EN): after reset, the first GAP cycle outputs bit 0 of 16'hACE1 (=1) and later gap bits follow the LFSR sequence; without the macro, gap bits are all 0.
